// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control sequencer: steps each instruction FETCH->DECODE->EXEC/MEM->WB and drives datapath selects/strobes.
// Latency: LW 5, SW/R/ADDI 4, BEQ/J 3 cycles with memory ready; outputs decode from the state register (pc_we/ir_we qualified).
// Backpressure: FETCH, MEMRD and MEMWR hold with requests asserted until mem_ready; enable only gates instruction start.
module cpu_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             iord,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             halted,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13,
        S_TRAP   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;
    logic             w_end_instr;
    state_t           w_after_instr;

    // MEMWR retires only on the cycle the write is accepted.
    always_comb begin
        w_end_instr = 1'b0;
        case (r_state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_end_instr = 1'b1;
            S_MEMWR:                                      w_end_instr = mem_ready;
            default:                                      w_end_instr = 1'b0;
        endcase
        w_after_instr = enable ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_retired <= '0;
        end else begin
            if (w_end_instr) begin
                r_retired <= r_retired + CNT_ONE;
            end
            case (r_state)
                S_IDLE:   r_state <= enable ? S_FETCH : S_IDLE;
                S_FETCH:  r_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:      r_state <= S_EXEC;
                        OP_LW, OP_SW:  r_state <= S_MEMADR;
                        OP_BEQ:        r_state <= S_BRANCH;
                        OP_ADDI:       r_state <= S_ADDIEX;
                        OP_J:          r_state <= S_JUMP;
                        OP_HALT:       r_state <= S_HALT;
                        default:       r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR: r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:  r_state <= mem_ready ? w_after_instr : S_MEMWR;
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                          r_state <= w_after_instr;
                S_HALT:   r_state <= S_HALT;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        halted     = 1'b0;
        trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_we     = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_we = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            S_HALT: halted = 1'b1;
            S_TRAP: trap   = 1'b1;
            default: ;
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: directed state-sequence walk plus a randomized instruction stream
// checked against a per-instruction cycle/strobe-count model.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        clear, enable, zero, mem_ready;
    logic [5:0]  opcode;
    logic        pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state;
    logic        halted, trap;
    logic [31:0] retired;
    logic [16:0] outs;

    int n_chk = 0;
    int n_err = 0;

    cpu_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .clear(clear), .enable(enable), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .iord(iord), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .state(state), .halted(halted),
        .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    assign outs = {pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, alu_op, pc_src, halted, trap};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected output vector for a state, straight from the per-state output table.
    function automatic logic [16:0] exp_outs(input int s, input logic r, input logic z);
        logic pw, iw, mr, mw, io, rw, rd, mtr, asa, hl, tr;
        logic [1:0] asb, aop, ps;
        {pw, iw, mr, mw, io, rw, rd, mtr, asa, hl, tr} = '0;
        asb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (s)
            1:  begin mr = 1; asb = 2'b01; pw = r; iw = r; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; io = 1; end
            5:  begin rw = 1; mtr = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; aop = 2'b01; ps = 2'b01; pw = z; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            12: begin ps = 2'b10; pw = 1; end
            13: hl = 1;
            14: tr = 1;
            default: ;
        endcase
        return {pw, iw, mr, mw, io, rw, rd, mtr, asa, asb, aop, ps, hl, tr};
    endfunction

    // Inputs are set by the caller at edge+1; sample at edge+2, then move to the next edge+1.
    task automatic ec(input string tag, input int s);
        #1;
        chk({tag, ".state"}, 64'(state), 64'(s));
        chk({tag, ".outs"}, 64'(outs), 64'(exp_outs(s, mem_ready, zero)));
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] OPS [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

    initial begin
        logic [31:0] exp_ret;
        clear = 1'b0; enable = 1'b0; zero = 1'b0; mem_ready = 1'b1; opcode = 6'h00;
        #1;
        chk("reset.state", 64'(state), 64'd0);
        chk("reset.outs", 64'(outs), 64'd0);
        chk("reset.retired", 64'(retired), 64'd0);
        repeat (2) @(posedge clk);
        #1 clear = 1'b1;

        for (int i = 0; i < 10; i++) begin
            chk("idle.retired", 64'(retired), 64'd0);
            ec("idle", 0);
        end
        enable = 1'b1;
        ec("idle_go", 0);

        // R-type
        opcode = 6'h00;
        ec("r.fetch", 1); ec("r.decode", 2); ec("r.exec", 7);
        chk("r.retired_pre", 64'(retired), 64'd0);
        ec("r.aluwb", 8);
        chk("r.retired", 64'(retired), 64'd1);

        // LW with three wait cycles in MEMRD
        opcode = 6'h23;
        ec("lw.fetch", 1); ec("lw.decode", 2);
        mem_ready = 1'b0;
        ec("lw.memadr", 3);
        for (int i = 0; i < 3; i++) ec("lw.memrd_wait", 4);
        mem_ready = 1'b1;
        ec("lw.memrd", 4); ec("lw.memwb", 5);
        chk("lw.retired", 64'(retired), 64'd2);

        // BEQ taken then not taken
        opcode = 6'h04; zero = 1'b1;
        ec("beq1.fetch", 1); ec("beq1.decode", 2); ec("beq1.branch", 9);
        chk("beq1.retired", 64'(retired), 64'd3);
        zero = 1'b0;
        ec("beq0.fetch", 1); ec("beq0.decode", 2); ec("beq0.branch", 9);
        chk("beq0.retired", 64'(retired), 64'd4);

        // enable dropped during EXEC: instruction completes, then IDLE
        opcode = 6'h00;
        ec("en.fetch", 1); ec("en.decode", 2);
        enable = 1'b0;
        ec("en.exec", 7); ec("en.aluwb", 8);
        chk("en.retired", 64'(retired), 64'd5);
        ec("en.idle", 0); ec("en.idle2", 0);
        enable = 1'b1;
        ec("en.resume", 0);

        // SW with two wait cycles
        opcode = 6'h2B;
        ec("sw.fetch", 1); ec("sw.decode", 2);
        mem_ready = 1'b0;
        ec("sw.memadr", 3); ec("sw.wait1", 6);
        chk("sw.retired_wait", 64'(retired), 64'd5);
        ec("sw.wait2", 6);
        mem_ready = 1'b1;
        ec("sw.memwr", 6);
        chk("sw.retired", 64'(retired), 64'd6);

        opcode = 6'h02;
        ec("j.fetch", 1); ec("j.decode", 2); ec("j.jump", 12);
        chk("j.retired", 64'(retired), 64'd7);

        opcode = 6'h08;
        ec("addi.fetch", 1); ec("addi.decode", 2); ec("addi.ex", 10); ec("addi.wb", 11);
        chk("addi.retired", 64'(retired), 64'd8);

        // randomized stream, starts in FETCH
        exp_ret = 32'd8;
        for (int n = 0; n < 40; n++) begin
            int op_i, t, s, e_cyc, e_memrd, e_memwr, e_pcwe, e_regwe;
            int c_memrd, c_memwr, c_pcwe, c_regwe, c_irwe;
            logic rdy [64];
            logic z;
            op_i = $urandom_range(0, 5);
            z = 1'($urandom_range(0, 1));
            for (int k = 0; k < 64; k++) rdy[k] = (k >= 20) ? 1'b1 : ($urandom_range(0, 2) != 0);

            // model: each memory phase ends on the first ready cycle
            t = 0;
            while (!rdy[t]) t++;
            t++;
            e_memrd = t; e_memwr = 0; e_pcwe = 1; e_regwe = 0;
            t++;
            case (op_i)
                0, 4: begin t += 2; e_regwe = 1; end
                5:    begin t += 1; e_pcwe += 1; end
                3:    begin t += 1; e_pcwe += int'(z); end
                1:    begin
                    t += 1; s = t;
                    while (!rdy[t]) t++;
                    t++; e_memrd += t - s; t += 1; e_regwe = 1;
                end
                default: begin
                    t += 1; s = t;
                    while (!rdy[t]) t++;
                    t++; e_memwr = t - s;
                end
            endcase
            e_cyc = t;

            chk("rnd.start_fetch", 64'(state), 64'd1);
            opcode = OPS[op_i]; zero = z;
            {c_memrd, c_memwr, c_pcwe, c_regwe, c_irwe} = '0;
            for (int k = 0; k < e_cyc; k++) begin
                mem_ready = rdy[k];
                #1;
                c_memrd += int'(mem_rd); c_memwr += int'(mem_wr);
                c_pcwe  += int'(pc_we);  c_regwe += int'(reg_we); c_irwe += int'(ir_we);
                if (k == e_cyc - 1) chk("rnd.retired_pre", 64'(retired), 64'(exp_ret));
                @(posedge clk);
                #1;
            end
            exp_ret++;
            chk("rnd.retired", 64'(retired), 64'(exp_ret));
            chk("rnd.memrd_cycles", 64'(c_memrd), 64'(e_memrd));
            chk("rnd.memwr_cycles", 64'(c_memwr), 64'(e_memwr));
            chk("rnd.pcwe_cycles", 64'(c_pcwe), 64'(e_pcwe));
            chk("rnd.regwe_cycles", 64'(c_regwe), 64'(e_regwe));
            chk("rnd.irwe_cycles", 64'(c_irwe), 64'd1);
        end

        // HALT is absorbing and freezes retired
        mem_ready = 1'b1; opcode = 6'h3F;
        ec("halt.fetch", 1); ec("halt.decode", 2);
        for (int i = 0; i < 4; i++) ec("halt.hold", 13);
        chk("halt.retired", 64'(retired), 64'(exp_ret));

        // asynchronous reset mid-cycle
        #2 clear = 1'b0;
        #1;
        chk("arst.state", 64'(state), 64'd0);
        chk("arst.outs", 64'(outs), 64'd0);
        chk("arst.retired", 64'(retired), 64'd0);
        @(posedge clk);
        #1 clear = 1'b1;

        // illegal opcode traps
        opcode = 6'h2A;
        ec("trap.idle", 0); ec("trap.fetch", 1); ec("trap.decode", 2);
        for (int i = 0; i < 3; i++) ec("trap.hold", 14);
        chk("trap.retired", 64'(retired), 64'd0);

        // reset during a memory wait drops the request immediately
        clear = 1'b0;
        #1 clear = 1'b1;
        mem_ready = 1'b0;
        ec("mw.idle", 0); ec("mw.fetch_wait", 1); ec("mw.fetch_wait2", 1);
        #2 clear = 1'b0;
        #1;
        chk("mw.arst_state", 64'(state), 64'd0);
        chk("mw.arst_memrd", 64'(mem_rd), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multicycle control sequencer for the 32-bit CPU datapath (PC, IR, register file, ALU, unified memory). It steps each instruction through fetch/decode/execute/memory/writeback states and drives every datapath mux select and write strobe. It handles the memory ready handshake and gates instruction start on the top-level `enable`. It also reports halt, illegal-opcode trap and a retired-instruction count.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, rising edge
clear  input  1  asynchronous active-low reset (0 = reset)
enable  input  1  run permission, sampled only at instruction boundaries
opcode  input  6  IR[31:26]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current read/write this cycle
pc_we  output  1  PC write strobe
ir_we  output  1  IR write strobe
mem_rd  output  1  memory read request
mem_wr  output  1  memory write request
iord  output  1  memory address select: 0=PC, 1=ALUOut
reg_we  output  1  register file write
reg_dst  output  1  write reg: 0=rt, 1=rd
mem_to_reg  output  1  writeback data: 0=ALUOut, 1=MDR
alu_src_a  output  1  0=PC, 1=rs
alu_src_b  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct-decoded
pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state encoding (debug)
halted  output  1  HALT executed
trap  output  1  illegal opcode decoded
retired  output  CNT_W  instructions completed

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, HALT=13, TRAP=14. Value 15 is unreachable; if it is entered, the next state is IDLE.
- Reset (clear=0, asynchronous): state=IDLE, retired=0. All strobes and selects are 0, and halted=trap=0.
- Outputs are Moore-decoded from state, except pc_we/ir_we, which are qualified by mem_ready in FETCH and by zero in BRANCH. Unlisted outputs are 0 in each state.
- IDLE: all outputs 0. Goes to FETCH when enable=1, otherwise stays.
- FETCH: mem_rd=1, alu_src_b=01, ir_we=pc_we=mem_ready. Stays in FETCH while mem_ready=0, goes to DECODE when mem_ready=1.
- DECODE: alu_src_b=11 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 (LW) or 101011 (SW) -> MEMADR
  - 000100 (BEQ) -> BRANCH
  - 001000 (ADDI) -> ADDIEX
  - 000010 (J) -> JUMP
  - 111111 -> HALT
  - any other opcode -> TRAP
- MEMADR: alu_src_a=1, alu_src_b=10. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_rd=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_we=1, mem_to_reg=1. End of instruction.
- MEMWR: mem_wr=1, iord=1. Holds until mem_ready=1. End of instruction on the ready cycle.
- EXEC: alu_src_a=1, alu_op=10, then goes to ALUWB.
- ALUWB: reg_we=1, reg_dst=1. End of instruction.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_we=zero. End of instruction.
- ADDIEX: alu_src_a=1, alu_src_b=10, then goes to ADDIWB.
- ADDIWB: reg_we=1. End of instruction.
- JUMP: pc_src=10, pc_we=1. End of instruction.
- End of instruction: retired increments by 1 on that clock edge. Next state is FETCH if enable=1, else IDLE.
- Enable timing: enable dropping mid-instruction does not abort; the instruction completes.
- HALT: halted=1; absorbing and does not increment retired. Only reset exits.
- TRAP: trap=1; absorbing and does not increment retired. Only reset exits.
- Memory requests: mem_rd/mem_wr stay asserted continuously while waiting. There is no timeout.
- Reset mid-instruction (including during a memory wait): immediate return to IDLE; all strobes deassert in the same cycle, without waiting for a clock edge.
- Instruction latency with mem_ready=1 throughout (FETCH to end of instruction inclusive):
  - LW: 5 cycles
  - SW, R-type, ADDI: 4 cycles
  - BEQ, J: 3 cycles

Test Plan:
- Reset with enable=0, then release → state=0, all outputs 0 and retired=0 for 10 cycles; set enable=1 → state=1 on the next edge.
- R-type (opcode=0), mem_ready=1 → state sequence 1,2,7,8,1; reg_we=1 and reg_dst=1 only in state 8; retired=1 after 4 cycles.
- LW with mem_ready held 0 for 3 cycles in MEMRD → mem_rd=1 and iord=1 for 4 cycles; MEMWB has mem_to_reg=1; total 8 cycles; retired increments once.
- BEQ with zero=1 → pc_we=1 and pc_src=01 in BRANCH. Repeat with zero=0 → pc_we=0; retired still increments.
- Drop enable during EXEC → ALUWB completes, then state=0 (IDLE). Re-assert enable → FETCH resumes.
- Opcode 0x3F → state 13, halted=1, retired frozen. Opcode 0x2A → state 14, trap=1. Assert clear=0 mid-state → state=0 immediately, asynchronously.
